// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier: S digits per cycle into a 2N-bit accumulator,
// followed by one fixed correction cycle for an unsigned multiplier, then a valid/ready output.

module booth_decoder #(
   parameter int N = 32,
   parameter int S = 4
) (
   input  logic [N-1:0]                     b,
   output logic [N/(2*S)-1:0][S-1:0][2:0]   o_data
);
   localparam int K = N / (2 * S);

   logic [N:0] bx;
   assign bx = {b, 1'b0};  // b[-1] = 0

   for (genvar g = 0; g < K; g++) begin : g_grp
      for (genvar s = 0; s < S; s++) begin : g_dig
         assign o_data[g][s] = bx[2*(g*S+s)+2 -: 3];
      end
   end
endmodule

module booth_mul_iter #(
   parameter int N = 32,
   parameter int S = 4
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic [N-1:0]   i_multiplicand,
   input  logic [N-1:0]   i_multiplier,
   input  logic           i_signed_a,
   input  logic           i_signed_b,
   input  logic           i_abort,
   output logic           o_valid,
   input  logic           i_ready,
   output logic [2*N-1:0] o_product
);
   localparam int M  = N / 2;
   localparam int K  = M / S;
   localparam int CW = (K > 1) ? $clog2(K) : 1;

   if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("booth_mul_iter: N must be a power of 2 and >= 4");
   end
   if (S < 1 || (M % S) != 0) begin : g_bad_s
      $error("booth_mul_iter: S must be >= 1 and divide N/2");
   end

   typedef enum logic [1:0] {IDLE, RUN, CORR, DONE} state_t;

   state_t                   state, state_n;
   logic [N:0]               a_ext;
   logic [N-1:0]             b_reg;
   logic                     sb_reg;
   logic [2*N-1:0]           acc, sum, a_wide, pp;
   logic [CW-1:0]            cnt;
   logic [K-1:0][S-1:0][2:0] groups;
   logic                     accept;

   booth_decoder #(.N(N), .S(S)) u_dec (
      .b      (b_reg),
      .o_data (groups)
   );

   assign o_ready = (state == IDLE);
   assign accept  = i_valid && (state == IDLE) && !i_abort;
   assign a_wide  = {{(N-1){a_ext[N]}}, a_ext};

   always_comb begin
      state_n = state;
      if (i_abort) state_n = IDLE;
      else begin
         case (state)
            IDLE: if (accept) state_n = RUN;
            RUN:  if (cnt == CW'(K - 1)) state_n = CORR;
            CORR: state_n = DONE;
            DONE: if (i_ready) state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // One iteration's S partial products, or the unsigned-B correction in CORR.
   always_comb begin
      sum = acc;
      pp  = '0;
      if (state == RUN) begin
         for (int s = 0; s < S; s++) begin
            case (groups[cnt][s])
               3'b001, 3'b010: pp = a_wide;
               3'b011:         pp = a_wide << 1;
               3'b100:         pp = -(a_wide << 1);
               3'b101, 3'b110: pp = -a_wide;
               default:        pp = '0;
            endcase
            sum = sum + (pp << (2 * (int'(cnt) * S + s)));
         end
      end else if (state == CORR) begin
         if (!sb_reg && b_reg[N-1]) sum = acc + (a_wide << N);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         a_ext     <= '0;
         b_reg     <= '0;
         sb_reg    <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         o_valid   <= 1'b0;
         o_product <= '0;
      end else begin
         state <= state_n;
         if (i_abort) o_valid <= 1'b0;
         else begin
            case (state)
               IDLE: if (accept) begin
                  a_ext  <= {i_signed_a & i_multiplicand[N-1], i_multiplicand};
                  b_reg  <= i_multiplier;
                  sb_reg <= i_signed_b;
                  acc    <= '0;
                  cnt    <= '0;
               end
               RUN: begin
                  acc <= sum;
                  cnt <= cnt + 1'b1;
               end
               CORR: begin
                  o_product <= sum;
                  o_valid   <= 1'b1;
               end
               DONE: if (i_ready) o_valid <= 1'b0;
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_booth_mul_iter.sv
// Directed + random checks of booth_mul_iter against a plain-arithmetic product model.

module tb_booth_mul_iter;
   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_multiplicand = '0;
   logic [31:0] i_multiplier = '0;
   logic        i_signed_a = 1'b0;
   logic        i_signed_b = 1'b0;
   logic        i_abort = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [63:0] o_product;

   int          total = 0;
   int          passed = 0;
   logic [63:0] last_prod = '0;

   booth_mul_iter #(.N(32), .S(4)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_multiplicand(i_multiplicand), .i_multiplier(i_multiplier),
      .i_signed_a(i_signed_a), .i_signed_b(i_signed_b), .i_abort(i_abort),
      .o_valid(o_valid), .i_ready(i_ready), .o_product(o_product)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb);
      logic [63:0] ax, bx;
      ax = sa ? {{32{a[31]}}, a} : {32'd0, a};
      bx = sb ? {{32{b[31]}}, b} : {32'd0, b};
      return ax * bx;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic start(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb);
      int guard;
      guard = 0;
      @(negedge i_clk);
      while (!o_ready && guard < 30) begin
         @(negedge i_clk);
         guard++;
      end
      chk("ready_before_accept", {63'd0, o_ready}, 64'd1);
      i_multiplicand = a; i_multiplier = b; i_signed_a = sa; i_signed_b = sb;
      i_valid = 1'b1;
      @(posedge i_clk);
      #1 i_valid = 1'b0;
   endtask

   task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic sb, input bit hold);
      int lat;
      logic [63:0] exp;
      exp = ref_mul(a, b, sa, sb);
      i_ready = !hold;
      start(a, b, sa, sb);
      lat = 0;
      while (!o_valid && lat < 20) begin
         @(posedge i_clk);
         #1 lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd5);
      chk({tag, "_product"}, o_product, exp);
      if (hold) begin
         i_valid = 1'b1;  // must not be taken while DONE
         for (int i = 0; i < 3; i++) begin
            @(posedge i_clk);
            #1;
            chk({tag, "_hold_valid"}, {63'd0, o_valid}, 64'd1);
            chk({tag, "_hold_product"}, o_product, exp);
            chk({tag, "_hold_ready"}, {63'd0, o_ready}, 64'd0);
         end
         i_ready = 1'b1;
      end
      @(posedge i_clk);
      #1;
      chk({tag, "_valid_fall"}, {63'd0, o_valid}, 64'd0);
      chk({tag, "_ready_rise"}, {63'd0, o_ready}, 64'd1);
      i_valid = 1'b0;
      last_prod = exp;
   endtask

   initial begin
      #12;
      chk("rst_ready", {63'd0, o_ready}, 64'd1);
      chk("rst_valid", {63'd0, o_valid}, 64'd0);
      chk("rst_product", o_product, 64'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      do_mul("neg3x7",   32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
      chk("neg3x7_const", last_prod, 64'hFFFF_FFFF_FFFF_FFEB);
      do_mul("umax",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      chk("umax_const", last_prod, 64'hFFFF_FFFE_0000_0001);
      do_mul("mulhsu",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      chk("mulhsu_const", last_prod, 64'h8000_0000_8000_0000);
      do_mul("minxmin",  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
      chk("minxmin_const", last_prod, 64'h4000_0000_0000_0000);
      do_mul("zero",     32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
      do_mul("hold",     32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b1);

      for (int i = 0; i < 16; i++) begin
         logic [31:0] a, b;
         logic [1:0]  sg;
         a = $urandom; b = $urandom; sg = 2'($urandom_range(0, 3));
         do_mul("rand", a, b, sg[1], sg[0], (i % 5) == 4);
      end

      // Abort during RUN: no result, back to IDLE, product untouched.
      start(32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0);
      @(posedge i_clk);
      #1 i_abort = 1'b1;
      @(posedge i_clk);
      #1 i_abort = 1'b0;
      chk("abort_ready", {63'd0, o_ready}, 64'd1);
      chk("abort_valid", {63'd0, o_valid}, 64'd0);
      chk("abort_product", o_product, last_prod);
      for (int i = 0; i < 8; i++) begin
         @(posedge i_clk);
         #1 chk("abort_no_valid", {63'd0, o_valid}, 64'd0);
      end

      // Abort beats a simultaneous valid in IDLE.
      @(negedge i_clk);
      i_valid = 1'b1; i_abort = 1'b1;
      @(posedge i_clk);
      #1 i_valid = 1'b0; i_abort = 1'b0;
      chk("abort_idle_ready", {63'd0, o_ready}, 64'd1);
      for (int i = 0; i < 7; i++) begin
         @(posedge i_clk);
         #1 chk("abort_idle_no_valid", {63'd0, o_valid}, 64'd0);
      end

      // Asynchronous reset mid-RUN.
      start(32'h0BAD_F00D, 32'h0000_0003, 1'b1, 1'b1);
      @(posedge i_clk);
      @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", {63'd0, o_ready}, 64'd1);
      chk("mid_rst_valid", {63'd0, o_valid}, 64'd0);
      chk("mid_rst_product", o_product, 64'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      do_mul("after_rst", 32'hFFFF_FFF0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/booth_mul_iter.md
# booth_mul_iter

Iterative radix-4 Booth multiplier core for the RISC-V M-extension datapath. It sits directly downstream of `booth_decoder`, which it instantiates on its registered multiplier operand. Each cycle it consumes one group of S Booth digits, forms the S partial products and adds them into a 2N-bit accumulator. After K iterations and one unsigned-correction cycle it presents the full 2N-bit product behind a valid/ready handshake.

## Interface
- `N`, default 32: operand width; must be a power of 2 and ≥ 4.
- `S`, default 4: Booth digits consumed per iteration; must be ≥ 1 and must divide N/2.
- Derived localparams: M = N/2 (number of digits), K = M/S (number of iterations).
- `i_clk`, input, 1: clock. One clock domain.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_valid`, input, 1: operands valid.
- `o_ready`, output, 1: block can accept operands; equals (state == IDLE).
- `i_multiplicand`, input, N: operand A.
- `i_multiplier`, input, N: operand B.
- `i_signed_a`, input, 1: A is two's complement (1) or unsigned (0).
- `i_signed_b`, input, 1: B is two's complement (1) or unsigned (0).
- `i_abort`, input, 1: synchronous flush, e.g. on pipeline kill.
- `o_valid`, output, 1: `o_product` valid.
- `i_ready`, input, 1: consumer accepts the product.
- `o_product`, output, 2N: full product A×B mod 2^(2N).

## Operation
- States:
  - IDLE → RUN on `i_valid && o_ready && !i_abort`.
  - RUN → RUN while cnt < K-1; RUN → CORR when cnt == K-1.
  - CORR → DONE.
  - DONE → IDLE on `i_ready`.
- On accept, the block registers:
  - A_ext = {`i_signed_a` & A[N-1], A}, which is N+1 bits;
  - B;
  - `i_signed_b`.
  - It also clears the accumulator and sets cnt = 0.
- `booth_decoder` is fed the registered B. RUN iteration `cnt` uses group `o_data[cnt]`. Digit s in that group has global index j = cnt*S + s and weight 2^(2j).
- Digit triplet {b[2j+1], b[2j], b[2j-1]} with b[-1] = 0 maps as follows:
  - 000 or 111 → 0
  - 001 or 010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101 or 110 → −A
- Partial products are sign-extended from A_ext. Negation is two's complement. All S partial products plus the accumulator are summed in a single cycle, and all arithmetic is modulo 2^(2N).
- The Booth recoding treats B as signed. In CORR, if `!signed_b && B[N-1]`, the block adds A_ext << N. Otherwise it adds 0. CORR is always taken, so latency is fixed.
- The CORR edge loads `o_product` from the final sum and sets `o_valid`.
- `o_product` and `o_valid` hold stable while `o_valid && !i_ready`.
- `i_abort` in any state forces IDLE at the next edge, clears `o_valid` and leaves `o_product` unchanged.
  - In IDLE with `i_valid` also high, abort wins and nothing is accepted.
- No new operands are accepted in DONE, even when `i_valid && i_ready` are both high in that cycle. `o_ready` rises the cycle after the output handshake.
- Elaboration errors are raised for any invalid N or S.

## Timing
- Reset values: state = IDLE, `o_ready` = 1, `o_valid` = 0, `o_product` = 0, accumulator = 0, cnt = 0.
- Reset asserted mid-operation returns the block to IDLE immediately, asynchronously.
- Accept edge is t0. RUN edges are t1..tK, CORR edge is tK+1. `o_valid` is high from the cycle after tK+1.
  - Latency is K+1 cycles from acceptance. N=32, S=4 gives 5.
- Throughput is one multiply per K+3 cycles at best: K+1 busy cycles, one DONE cycle with `i_ready` high, and one IDLE cycle.
- `o_ready` is a pure decode of registered state. There is no combinational path from any input to `o_ready` or `o_valid`.

## Test plan
- A=0xFFFFFFFD, B=0x00000007, both signed → `o_product` = 0xFFFFFFFF_FFFFFFEB, `o_valid` 5 cycles after accept.
- A=B=0xFFFFFFFF, both unsigned → 0xFFFFFFFE_00000001; CORR adds A<<32.
- A=0x80000000 signed, B=0xFFFFFFFF unsigned (MULHSU) → 0x80000000_80000000.
- A=B=0x80000000, both signed → 0x40000000_00000000. A=0 with any B → 0.
- Hold `i_ready` low for 3 cycles after `o_valid` → `o_product` and `o_valid` stable and `o_ready` = 0 throughout. On the handshake, `o_valid` falls at the next edge and `o_ready` rises.
- Abort:
  - Assert `i_abort` at RUN cycle 2 → no `o_valid`, and `o_ready` is 1 the next cycle.
  - Repeat the check with `i_rst_n` pulsed low mid-RUN → all outputs at reset values immediately.
  - A following multiply gives the correct result.
